// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
// Load/store has priority; fetch wins after MAX_WAIT consecutive lost arbitrations.

module mem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LP_RD_LAT   = 3'(RD_LAT);
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [2:0] r_wait_cnt;
    logic [3:0] r_starve_cnt;
    logic       r_owner_ls;

    logic w_any_req;
    logic w_pick_ls;
    logic w_pick_if;
    logic w_sample;
    logic w_capture;

    logic              w_nx_mem_en;
    logic              w_nx_mem_we;
    logic [ADDR_W-1:0] w_nx_mem_addr;
    logic [DATA_W-1:0] w_nx_mem_wdata;
    logic              w_nx_if_gnt;
    logic              w_nx_ls_gnt;
    logic              w_nx_if_rvalid;
    logic              w_nx_ls_rvalid;

    assign w_any_req = if_req | ls_req;
    assign w_pick_ls = ls_req & ~(if_req & (r_starve_cnt == LP_MAX_WAIT));
    assign w_pick_if = if_req & ~w_pick_ls;
    assign w_sample  = (r_state == S_IDLE) & w_any_req;
    // Last WAIT cycle: mem_rdata is valid exactly now.
    assign w_capture = (r_state == S_WAIT) & (r_wait_cnt <= 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = mem_we ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt <= 3'd1) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Next values for the registered outputs; ISSUE outputs are decided in IDLE.
    always_comb begin
        w_nx_mem_en    = 1'b0;
        w_nx_mem_we    = 1'b0;
        w_nx_mem_addr  = '0;
        w_nx_mem_wdata = '0;
        w_nx_if_gnt    = 1'b0;
        w_nx_ls_gnt    = 1'b0;
        w_nx_if_rvalid = 1'b0;
        w_nx_ls_rvalid = 1'b0;
        if (w_sample) begin
            w_nx_mem_en = 1'b1;
            w_nx_if_gnt = w_pick_if;
            w_nx_ls_gnt = w_pick_ls;
            if (w_pick_ls) begin
                w_nx_mem_addr = ls_addr;
                w_nx_mem_we   = ls_we;
                if (ls_we) begin
                    w_nx_mem_wdata = ls_wdata;
                end
            end else begin
                w_nx_mem_addr = if_addr;
            end
        end
        if (w_capture) begin
            w_nx_if_rvalid = ~r_owner_ls;
            w_nx_ls_rvalid = r_owner_ls;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
        end else begin
            mem_en    <= w_nx_mem_en;
            mem_we    <= w_nx_mem_we;
            mem_addr  <= w_nx_mem_addr;
            mem_wdata <= w_nx_mem_wdata;
            if_gnt    <= w_nx_if_gnt;
            ls_gnt    <= w_nx_ls_gnt;
            if_rvalid <= w_nx_if_rvalid;
            ls_rvalid <= w_nx_ls_rvalid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_owner_ls   <= 1'b0;
        end else begin
            if (r_state == S_ISSUE && !mem_we) begin
                r_wait_cnt <= LP_RD_LAT;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (w_sample) begin
                r_owner_ls <= w_pick_ls;
                if (w_pick_if) begin
                    r_starve_cnt <= '0;
                end else if (if_req && r_starve_cnt != LP_MAX_WAIT) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
        end
    end

    // Read data registers hold until the next capture for the same port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata <= '0;
            ls_rdata <= '0;
        end else if (w_capture) begin
            if (r_owner_ls) begin
                ls_rdata <= mem_rdata;
            end else begin
                if_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port 4K-word RAM between two requesters: instruction fetch (read-only) and load/store (read or write).
- Sits between the fetch and execute logic and the RAM array.
- Sequences each access as issue, then wait for fixed read latency, then return data.
- Load/store has priority; a starvation bound guarantees fetch progress. At most one access is outstanding.

Parameters:
ADDR_W  12  RAM word-address width
DATA_W  32  RAM word width
RD_LAT  1   cycles from mem_en (read) to valid mem_rdata; legal range 1..7
MAX_WAIT  4  consecutive lost arbitrations after which fetch wins; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  ADDR_W  fetch address; stable while if_req
if_gnt  output  1  one-cycle pulse: fetch access issued this cycle
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DATA_W  fetch read data
ls_req  input  1  load/store request; held until ls_gnt
ls_we  input  1  1 = store, 0 = load; stable while ls_req
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  one-cycle pulse: load/store access issued this cycle
ls_rvalid  output  1  one-cycle pulse: ls_rdata valid (loads only)
ls_rdata  output  DATA_W  load read data
mem_en  output  1  RAM access strobe
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid RD_LAT cycles after mem_en

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; every output 0; wait counter 0; starvation counter 0.
- Reset asserted mid-access aborts the access: no rvalid is produced and state returns to IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE: requests are sampled at the clock edge. The next state is ISSUE if any request is high, otherwise IDLE.
- Winner selection:
  - ls_req only: load/store wins.
  - if_req only: fetch wins.
  - Both high: load/store wins unless starve_cnt == MAX_WAIT, in which case fetch wins.
- starve_cnt:
  - Increments when both requests are high and load/store wins.
  - Clears whenever fetch is granted.
  - Saturates at MAX_WAIT.
- ISSUE (exactly 1 cycle):
  - mem_en=1. mem_addr is the winner's address.
  - mem_we = ls_we for load/store, 0 for fetch. mem_wdata = ls_wdata on a store, else 0.
  - The winner's gnt = 1.
  - Next state: store goes to IDLE; any read goes to WAIT with counter = RD_LAT.
- Outside ISSUE, mem_en, mem_we, mem_addr, mem_wdata and both gnt are 0.
- Requests are ignored in ISSUE and WAIT. A requester sees gnt in ISSUE and must drop or replace its request by the following edge.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where counter == 1, mem_rdata is captured into the owner's rdata register.
  - The owner's rvalid is 1 in the following cycle, which is IDLE.
- Read timing: ISSUE in cycle T; rvalid/rdata in cycle T+RD_LAT+1; earliest next ISSUE at T+RD_LAT+2.
- Store timing: ISSUE in cycle T; earliest next ISSUE at T+2.
- if_rdata and ls_rdata each hold their last captured value until their next capture. They are never cleared except by reset.
- Only one rvalid can be high in any cycle, and only for the port that owned the read.
- A request that drops in IDLE before being sampled is lost silently. No error is flagged.

Test Plan:
- Reset: assert rst for 2 cycles with if_req=1 -> all outputs 0, no gnt; release rst -> if_gnt one cycle later.
- Fetch read, RD_LAT=1: if_req=1, if_addr=0x005, RAM[5]=0x8C220004.
  - mem_en=1, mem_we=0, mem_addr=0x005, if_gnt=1 in cycle T.
  - if_rvalid=1, if_rdata=0x8C220004 in T+2.
  - ls_rvalid stays 0.
- Store: ls_req=1, ls_we=1, ls_addr=0x0FF, ls_wdata=0xDEADBEEF.
  - mem_en=1, mem_we=1, mem_addr=0x0FF, mem_wdata=0xDEADBEEF, ls_gnt=1 for one cycle.
  - No ls_rvalid. IDLE the next cycle.
- Simultaneous requests: if_req=1 and ls_req=1 (load, addr 0x010) in the same cycle -> ls_gnt first. if_gnt at ISSUE+RD_LAT+2 when ls_req is dropped.
- Starvation, MAX_WAIT=4: ls_req held high continuously with new loads, if_req high -> four ls_gnt pulses, then the fifth grant is if_gnt; starve_cnt is 0 after it.
- Reset mid-read, RD_LAT=3: assert rst in the second WAIT cycle -> no if_rvalid or ls_rvalid ever appears for that access; if_rdata=0; next request is granted normally.
